// File: rtl/digit_serial_adder_if.sv
// Operand/result handshake bundle for digit_serial_adder.
// The master modport belongs to the producer/consumer side, and the slave modport belongs to the adder.
interface digit_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             approx_en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;

    modport master (
        output in_valid, a, b, c_in, approx_en, out_ready,
        input  in_ready, out_valid, sum, c_out
    );

    modport slave (
        input  in_valid, a, b, c_in, approx_en, out_ready,
        output in_ready, out_valid, sum, c_out
    );
endinterface

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder that adds DIGIT bits per clock, LSB digit first, through one registered carry.
// When approx_en is latched high, the APPROX_LSBS low bits use OR in place of addition and propagate no carry.
module digit_serial_adder #(
    parameter int WIDTH       = 16,
    parameter int DIGIT       = 4,
    parameter int APPROX_LSBS = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    digit_serial_adder_if.slave bus
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             approx_r;
    logic [WIDTH-1:0] sum_r;
    logic             c_out_r;

    int               base;
    logic [DIGIT-1:0] d_a;
    logic [DIGIT-1:0] d_b;
    logic [DIGIT-1:0] d_sum;
    logic             d_cout;
    logic             c;

    assign bus.in_ready  = rst_n && (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.sum       = sum_r;
    assign bus.c_out     = c_out_r;

    // Ripple through the current digit. The approx/exact choice is made per bit, so an
    // approximation boundary may fall anywhere inside a digit.
    always_comb begin
        // NOTE: every variable gets a default first so that no path infers a latch.
        base  = int'(cnt) * DIGIT;
        d_a   = a_r[base +: DIGIT];
        d_b   = b_r[base +: DIGIT];
        d_sum = '0;
        c     = carry;
        for (int j = 0; j < DIGIT; j++) begin
            if (approx_r && (base + j < APPROX_LSBS)) begin
                d_sum[j] = d_a[j] | d_b[j];
                c        = 1'b0;
            end else begin
                d_sum[j] = d_a[j] ^ d_b[j] ^ c;
                c        = (d_a[j] & d_b[j]) | (d_a[j] & c) | (d_b[j] & c);
            end
        end
        d_cout = c;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only. Reset is synchronous,
        // and the operand registers are also cleared so that no stale operand survives an abort.
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            carry    <= 1'b0;
            a_r      <= '0;
            b_r      <= '0;
            approx_r <= 1'b0;
            sum_r    <= '0;
            c_out_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r      <= bus.a;
                        b_r      <= bus.b;
                        approx_r <= bus.approx_en;
                        carry    <= bus.c_in;
                        cnt      <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum_r[base +: DIGIT] <= d_sum;
                    carry                <= d_cout;
                    if (cnt == LAST) begin
                        c_out_r <= d_cout;
                        cnt     <= '0;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed and randomized self-checking bench for digit_serial_adder (WIDTH=16, DIGIT=4, APPROX_LSBS=4).
module tb_digit_serial_adder;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    digit_serial_adder_if #(.WIDTH(16)) bus ();

    digit_serial_adder #(.WIDTH(16), .DIGIT(4), .APPROX_LSBS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Exact mode: a plain 17-bit add. Approx mode: OR the low nibble, add the upper 12 bits with no carry-in.
    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic ap);
        logic [12:0] hi;
        if (!ap) return {1'b0, a} + {1'b0, b} + 17'(cin);
        hi = {1'b0, a[15:4]} + {1'b0, b[15:4]};
        return {hi, a[3:0] | b[3:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int n = 0; n < 20 && !bus.in_ready; n++) tick();
    endtask

    task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic ap);
        wait_ready();
        bus.a         = a;
        bus.b         = b;
        bus.c_in      = cin;
        bus.approx_en = ap;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic ap,
                          input logic [15:0] want_sum, input logic want_cout);
        int n;
        accept(a, b, cin, ap);
        wait_valid(n);
        check({tag, "_lat"}, n, 4);
        check({tag, "_sum"}, bus.sum, want_sum);
        check({tag, "_cout"}, bus.c_out, want_cout);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_ack"}, bus.out_valid, 0);
    endtask

    initial begin
        int          n;
        int          last_acc;
        logic [15:0] ra, rb;
        logic        rc, rap;
        logic [16:0] exp_v;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.c_in      = 1'b0;
        bus.approx_en = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_sum", bus.sum, 0);
        check("rst_cout", bus.c_out, 0);
        rst_n = 1'b1;
        #1;
        check("rst_rel_in_ready", bus.in_ready, 1);

        run_op("t1_ovf", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
        run_op("t2_exact", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0);
        // Low nibble 4|1=5, upper 0x123+0x432=0x555, c_in ignored.
        run_op("t2_approx", 16'h1234, 16'h4321, 1'b1, 1'b1, 16'h5555, 1'b0);
        run_op("t3_approx", 16'h000F, 16'h0001, 1'b0, 1'b1, 16'h000F, 1'b0);
        run_op("t3_exact", 16'h000F, 16'h0001, 1'b0, 1'b0, 16'h0010, 1'b0);
        run_op("t_approx_carry", 16'hF00F, 16'h1001, 1'b1, 1'b1, 16'h000F, 1'b1);

        // Backpressure: the result holds and new operands are refused while in DONE.
        accept(16'h1111, 16'h2222, 1'b0, 1'b0);
        wait_valid(n);
        check("bp_lat", n, 4);
        bus.a        = 16'hAAAA;
        bus.b        = 16'h5555;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_sum", bus.sum, 16'h3333);
            check("bp_cout", bus.c_out, 0);
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_out_valid", bus.out_valid, 1);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("bp_rel_in_ready", bus.in_ready, 1);
        check("bp_rel_out_valid", bus.out_valid, 0);
        check("bp_rel_sum_hold", bus.sum, 16'h3333);

        // Reset during the second RUN cycle aborts the operation.
        accept(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", bus.in_ready, 0);
        tick();
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_sum", bus.sum, 0);
        check("mid_rst_cout", bus.c_out, 0);
        rst_n = 1'b1;
        #1;
        check("mid_rst_idle", bus.in_ready, 1);
        run_op("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0);

        // Back-to-back operation: in_valid and out_ready tied high, random operands in both modes.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        last_acc      = 0;
        for (int i = 0; i < 1000; i++) begin
            wait_ready();
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rc  = 1'($urandom_range(0, 1));
            rap = 1'($urandom_range(0, 1));
            bus.a         = ra;
            bus.b         = rb;
            bus.c_in      = rc;
            bus.approx_en = rap;
            exp_v = model(ra, rb, rc, rap);
            if (i > 0) check("b2b_period", cyc - last_acc, 6);
            last_acc = cyc;
            tick();
            wait_valid(n);
            check("b2b_lat", n, 4);
            check("b2b_sum", bus.sum, exp_v[15:0]);
            check("b2b_cout", bus.c_out, exp_v[16]);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
